// File: rtl/tf520_eclk_vma.sv
// 6800-style E clock and VMA/EDTACK generator for synchronous CIA cycles on the Amiga-side 68000 bus.
// A free-running E phase counter times the cycle. A small FSM aligns VPA requests to that counter.
module tf520_eclk_vma #(
    parameter int E_LOW   = 6,
    parameter int E_HIGH  = 4,
    parameter int VMA_CNT = 3
) (
    input  logic       CLK7M,
    input  logic       RESET,
    input  logic       AS,
    input  logic       VPA,
    output logic       E,
    output logic       VMA,
    output logic       EDTACK,
    output logic [3:0] ECNT
);

    localparam logic [3:0] cnt_last   = 4'(E_LOW + E_HIGH - 1);
    localparam logic [3:0] cnt_edtack = 4'(E_LOW + E_HIGH - 2);
    localparam logic [3:0] cnt_vma    = 4'(VMA_CNT);
    localparam logic [3:0] cnt_rise   = 4'(E_LOW);

    typedef enum logic [1:0] {
        s_idle,
        s_wait,
        s_assert,
        s_done
    } state_t;

    state_t     state;
    logic [3:0] next_cnt;
    logic       vpa_meta;
    logic       vpa_s;
    logic       req;

    if (VMA_CNT < 0 || VMA_CNT >= E_LOW - 1 || E_LOW + E_HIGH > 16) begin : g_param_check
        $error("tf520_eclk_vma: VMA_CNT must lie in 0..E_LOW-2 and the period must fit in ECNT");
    end

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        next_cnt = ECNT + 4'd1;
        if (ECNT == cnt_last) begin
            next_cnt = '0;
        end
    end

    // E is decoded from the next count so that it changes on the same edge as ECNT.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK7M or negedge RESET) begin
        if (!RESET) begin
            ECNT <= '0;
            E    <= 1'b0;
        end else begin
            ECNT <= next_cnt;
            E    <= (next_cnt >= cnt_rise);
        end
    end

    // The synchroniser resets to the inactive level so that no request appears while reset is released.
    always_ff @(posedge CLK7M or negedge RESET) begin
        if (!RESET) begin
            vpa_meta <= 1'b1;
            vpa_s    <= 1'b1;
        end else begin
            vpa_meta <= VPA;
            vpa_s    <= vpa_meta;
        end
    end

    assign req = !AS && !vpa_s;

    // NOTE: only control flops are reset here; this block has no storage arrays that would need clearing.
    always_ff @(posedge CLK7M or negedge RESET) begin
        if (!RESET) begin
            state  <= s_idle;
            VMA    <= 1'b1;
            EDTACK <= 1'b1;
        end else begin
            case (state)
                s_idle: begin
                    if (req) begin
                        if (ECNT == cnt_vma) begin
                            state <= s_assert;
                            VMA   <= 1'b0;
                        end else begin
                            state <= s_wait;
                        end
                    end
                end
                // A late request waits here for the next period and never joins an E phase already under way.
                s_wait: begin
                    if (AS) begin
                        state <= s_idle;
                        VMA   <= 1'b1;
                    end else if (req && ECNT == cnt_vma) begin
                        state <= s_assert;
                        VMA   <= 1'b0;
                    end
                end
                s_assert: begin
                    if (AS) begin
                        state <= s_idle;
                        VMA   <= 1'b1;
                    end else if (ECNT == cnt_edtack) begin
                        state  <= s_done;
                        EDTACK <= 1'b0;
                    end
                end
                s_done: begin
                    EDTACK <= 1'b1;
                    if (AS) begin
                        state <= s_idle;
                        VMA   <= 1'b1;
                    end
                end
                default: begin
                    state  <= s_idle;
                    VMA    <= 1'b1;
                    EDTACK <= 1'b1;
                end
            endcase
        end
    end

endmodule
